paddle_tracker: RTL

Parametrised multi-channel column tracker for the camera-controlled pong display path. It watches the binary (eroded/dilated) video stream in raster order and samples NUM_CH configurable columns. For each channel it finds the longest vertical run of set pixels in the frame, computes that run's midpoint, and smooths it across frames with an IIR filter. The result is a registered per-channel paddle Y position and a found/not-found flag, updated once per frame and consumed by the ball/paddle game logic.

---
 rtl/paddle_tracker_if.sv | 26 ++
 rtl/paddle_tracker.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/paddle_tracker_if.sv
// Video-in / paddle-out bundle between the pixel pipeline and the paddle tracker.
// The slave modport is the tracker; the master is the video source and game logic.
interface paddle_tracker_if #(
   parameter int NUM_CH  = 2,
   parameter int COORD_W = 10
);
   logic                        pix_valid;
   logic [COORD_W-1:0]          draw_x;
   logic [COORD_W-1:0]          draw_y;
   logic                        pix_in;
   logic                        frame_end;
   logic [NUM_CH*COORD_W-1:0]   ch_x;
   logic [NUM_CH*COORD_W-1:0]   center;
   logic [NUM_CH-1:0]           center_valid;
   logic                        frame_done;

   modport master (
      output pix_valid, draw_x, draw_y, pix_in, frame_end, ch_x,
      input  center, center_valid, frame_done
   );

   modport slave (
      input  pix_valid, draw_x, draw_y, pix_in, frame_end, ch_x,
      output center, center_valid, frame_done
   );
endinterface

// File: rtl/paddle_tracker.sv
// Multi-column paddle tracker: longest vertical run per sampled column, midpoint,
// IIR-smoothed across frames; results refresh on the edge that samples frame_end.
module paddle_tracker #(
   parameter int NUM_CH       = 2,
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int COORD_W      = 10,
   parameter int MIN_RUN      = 8,
   parameter int SMOOTH_SHIFT = 2,
   parameter int DEFAULT_POS  = 240
) (
   input  logic            CLK,
   input  logic            RST_N,
   paddle_tracker_if.slave bus
);
   localparam int                        SW       = COORD_W + 2;
   localparam logic [COORD_W-1:0]        LP_V_RES = COORD_W'(V_RES);
   localparam logic [COORD_W-1:0]        LP_V_LST = COORD_W'(V_RES - 1);
   localparam logic [COORD_W-1:0]        LP_MIN   = COORD_W'(MIN_RUN);
   localparam logic [COORD_W-1:0]        LP_DEF   = COORD_W'(DEFAULT_POS);
   localparam logic signed [SW-1:0]      LP_S_MAX = SW'(V_RES - 1);

   logic r_frame_done;

   // frame_done echoes frame_end one cycle later, aligned with the result update
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= bus.frame_end;
      end
   end

   assign bus.frame_done = r_frame_done;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [COORD_W-1:0]   w_chx;
      logic                 w_hit;
      logic                 w_close;
      logic                 w_act_n;
      logic [COORD_W-1:0]   w_start_n;
      logic [COORD_W-1:0]   w_len_n;
      logic [COORD_W-1:0]   w_bstart_n;
      logic [COORD_W-1:0]   w_blen_n;
      logic                 w_found_n;
      logic [COORD_W-1:0]   w_raw;
      logic signed [SW-1:0] w_diff;
      logic signed [SW-1:0] w_sum;
      logic [COORD_W-1:0]   w_filt;

      logic                 r_run_active;
      logic [COORD_W-1:0]   r_run_start;
      logic [COORD_W-1:0]   r_run_len;
      logic [COORD_W-1:0]   r_best_start;
      logic [COORD_W-1:0]   r_best_len;
      logic                 r_found;
      logic [COORD_W-1:0]   r_center;
      logic                 r_center_valid;

      assign w_chx = bus.ch_x[i*COORD_W +: COORD_W];
      assign w_hit = bus.pix_valid && !bus.frame_end && (bus.draw_x == w_chx) &&
                     (32'(bus.draw_x) < H_RES) && (32'(bus.draw_y) < V_RES);

      // run tracking, close rule (last row / zero pixel / frame_end) and smoothing
      always_comb begin
         w_act_n   = r_run_active;
         w_start_n = r_run_start;
         w_len_n   = r_run_len;
         w_close   = 1'b0;
         if (w_hit && bus.pix_in) begin
            if (!r_run_active) begin
               w_start_n = bus.draw_y;
               w_len_n   = COORD_W'(1);
               w_act_n   = 1'b1;
            end else if (r_run_len < LP_V_RES) begin
               w_len_n = r_run_len + COORD_W'(1);
            end else begin
               w_len_n = r_run_len;
            end
            w_close = (bus.draw_y == LP_V_LST);
         end else if (w_hit) begin
            w_close = r_run_active;
         end else begin
            w_close = bus.frame_end && r_run_active;
         end

         w_bstart_n = r_best_start;
         w_blen_n   = r_best_len;
         w_found_n  = r_found;
         if (w_close && (w_len_n >= LP_MIN) && (w_len_n > r_best_len)) begin
            w_bstart_n = w_start_n;
            w_blen_n   = w_len_n;
            w_found_n  = 1'b1;
         end else begin
            w_found_n  = r_found;
         end
         w_act_n = w_close ? 1'b0 : w_act_n;

         w_raw  = w_bstart_n + (w_blen_n >> 1);
         w_diff = $signed({2'b00, w_raw}) - $signed({2'b00, r_center});
         w_sum  = $signed({2'b00, r_center}) + (w_diff >>> SMOOTH_SHIFT);
         if (w_sum[SW-1]) begin
            w_filt = '0;
         end else if (w_sum > LP_S_MAX) begin
            w_filt = LP_V_LST;
         end else begin
            w_filt = w_sum[COORD_W-1:0];
         end
      end

      // per-frame state update; frame_end publishes results and clears the frame
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            r_run_active   <= 1'b0;
            r_run_start    <= '0;
            r_run_len      <= '0;
            r_best_start   <= '0;
            r_best_len     <= '0;
            r_found        <= 1'b0;
            r_center       <= LP_DEF;
            r_center_valid <= 1'b0;
         end else if (bus.frame_end) begin
            r_run_active   <= 1'b0;
            r_run_start    <= '0;
            r_run_len      <= '0;
            r_best_start   <= '0;
            r_best_len     <= '0;
            r_found        <= 1'b0;
            r_center       <= w_found_n ? w_filt : r_center;
            r_center_valid <= w_found_n;
         end else begin
            r_run_active   <= w_act_n;
            r_run_start    <= w_start_n;
            r_run_len      <= w_len_n;
            r_best_start   <= w_bstart_n;
            r_best_len     <= w_blen_n;
            r_found        <= w_found_n;
         end
      end

      assign bus.center[i*COORD_W +: COORD_W] = r_center;
      assign bus.center_valid[i]              = r_center_valid;
   end
endmodule
